// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg : ALU control codes and FSM state encoding shared by the MDU
//           and the ALU decoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

   localparam logic [3:0] ALU_MUL  = 4'b1000;
   localparam logic [3:0] ALU_MULU = 4'b1001;
   localparam logic [3:0] ALU_DIV  = 4'b1010;
   localparam logic [3:0] ALU_DIVU = 4'b1011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } mdu_state_t;

endpackage

`default_nettype wire

// File: rtl/mdu_step.sv
// ============================================================================
// mdu_step : one combinational iteration, either a shift-add multiply step
//            or a restoring-divide step, over an {acc_hi, acc_lo} pair.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH-1:0] nxt_hi,
   output logic [WIDTH-1:0] nxt_lo
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;
   logic             ge;

   always_comb begin
      sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      rem_sh = {acc_hi, acc_lo[WIDTH-1]};
      ge     = (rem_sh >= {1'b0, opnd});
      // The remainder is always below the divisor, so the difference fits WIDTH bits.
      diff   = rem_sh[WIDTH-1:0] - opnd;
      if (is_div) begin
         nxt_hi = ge ? diff : rem_sh[WIDTH-1:0];
         nxt_lo = {acc_lo[WIDTH-2:0], ge};
      end else begin
         nxt_hi = sum[WIDTH:1];
         nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/mdu_iter.sv
// ============================================================================
// mdu_iter : iterative MUL/MULU/DIV/DIVU unit owning HI/LO, with MTHI/MTLO.
//            Optional macro MDU_FAST_MUL_EN gives single-cycle multiplies.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   mdu_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] opnd;
   logic             is_div;
   logic             neg_res;
   logic             neg_rem;
   logic             div0;
`ifdef MDU_FAST_MUL_EN
   logic             fast;
`endif

   logic             op_div;
   logic             op_valid;
   logic             op_signed;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   logic [WIDTH-1:0]   step_hi;
   logic [WIDTH-1:0]   step_lo;
   logic [2*WIDTH-1:0] prod_mag;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   always_comb begin
      op_div    = (op == ALU_DIV) || (op == ALU_DIVU);
      op_valid  = op_div || (op == ALU_MUL) || (op == ALU_MULU);
      op_signed = (op == ALU_MUL) || (op == ALU_DIV);
      a_neg     = op_signed & a[WIDTH-1];
      b_neg     = op_signed & b[WIDTH-1];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;
   end

   mdu_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .is_div (is_div),
      .acc_hi (acc_hi),
      .acc_lo (acc_lo),
      .opnd   (opnd),
      .nxt_hi (step_hi),
      .nxt_lo (step_lo)
   );

   // Sign fix-up of the unsigned magnitudes left in the accumulator.
   // A zero divisor keeps the all-ones quotient and lets the remainder
   // fix-up reproduce the raw dividend.
   always_comb begin
      prod_mag = {acc_hi, acc_lo};
`ifdef MDU_FAST_MUL_EN
      if (fast) begin
         prod_mag = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, acc_lo};
      end
`endif
      prod_fix = neg_res ? -prod_mag : prod_mag;
      quo_fix  = (neg_res && !div0) ? -acc_lo : acc_lo;
      rem_fix  = neg_rem ? -acc_hi : acc_hi;
      if (is_div) begin
         res_hi = rem_fix;
         res_lo = quo_fix;
      end else begin
         res_hi = prod_fix[2*WIDTH-1:WIDTH];
         res_lo = prod_fix[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         opnd    <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         div0    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
`ifdef MDU_FAST_MUL_EN
         fast    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (hi_we) hi <= wdata;
               if (lo_we) lo <= wdata;
               if (start && !flush && op_valid) begin
                  acc_hi  <= '0;
                  acc_lo  <= op_div ? a_mag : b_mag;
                  opnd    <= op_div ? b_mag : a_mag;
                  is_div  <= op_div;
                  neg_res <= a_neg ^ b_neg;
                  neg_rem <= op_div & a_neg;
                  div0    <= op_div && (b == '0);
                  cnt     <= CNT_W'(WIDTH);
                  busy    <= 1'b1;
                  state   <= ST_RUN;
`ifdef MDU_FAST_MUL_EN
                  fast    <= !op_div;
                  if (!op_div) state <= ST_FIN;
`endif
               end
            end
            ST_RUN: begin
               if (flush) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  acc_hi <= step_hi;
                  acc_lo <= step_lo;
                  cnt    <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) state <= ST_FIN;
               end
            end
            ST_FIN: begin
               if (!flush) begin
                  hi   <= res_hi;
                  lo   <= res_lo;
                  done <= 1'b1;
               end
               cnt   <= '0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
// ============================================================================
// tb_mdu_iter : vector table of MDU operations plus hand-written sequences
//               for flush, reset, ignored start and MTHI/MTLO interaction.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mdu_iter;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        flush = 1'b0;
   logic        hi_we = 1'b0;
   logic        lo_we = 1'b0;
   logic [31:0] wdata = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int total = 0;
   int bad = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   mdu_iter #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic launch(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Called just after E0; returns just after the edge that raised done.
   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   function automatic int lat_of(input logic [3:0] o);
`ifdef MDU_FAST_MUL_EN
      if (o == ALU_MUL || o == ALU_MULU) return 1;
`endif
      return 33;
   endfunction

   vec_t vecs[12];
   int   n;
   int   seen;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{ALU_MUL,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[1]  = '{ALU_MULU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
      vecs[2]  = '{ALU_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{ALU_DIVU, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF};
      vecs[4]  = '{ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{ALU_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[6]  = '{ALU_MUL,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[7]  = '{ALU_DIVU, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
      vecs[8]  = '{ALU_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[9]  = '{ALU_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[10] = '{ALU_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      vecs[11] = '{ALU_MUL,  32'd6,        32'd7,        32'h00000000, 32'h0000002A};

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);

      // Back-to-back: each launch samples start on the first edge after done.
      for (int i = 0; i < 12; i++) begin
         launch(vecs[i].op, vecs[i].a, vecs[i].b);
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
         chk($sformatf("v%0d_done_lo", i), 32'(done), 32'd0);
         if (lat_of(vecs[i].op) > 1) chk($sformatf("v%0d_hold_hi", i), hi, m_hi);
         wait_done(n);
         chk($sformatf("v%0d_lat", i), n, lat_of(vecs[i].op));
         chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
         chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
         chk($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
         m_hi = vecs[i].hi; m_lo = vecs[i].lo;
      end
      @(posedge clk); #1;
      chk("done_pulse", 32'(done), 32'd0);

      // Invalid op code is ignored.
      launch(4'b0010, 32'd5, 32'd5);
      chk("badop_busy", 32'(busy), 32'd0);

      // start during a run is ignored.
      launch(ALU_DIVU, 32'd100, 32'd7);
      n = 0;
      while (!done && n < 100) begin
         if (n == 4) begin start = 1'b1; op = ALU_MULU; a = 32'd3; b = 32'd3; end
         @(posedge clk); #1;
         n++;
         if (n == 5) start = 1'b0;
      end
      chk("ign_lat", n, 33);
      chk("ign_hi", hi, 32'd2);
      chk("ign_lo", lo, 32'd14);
      m_hi = 32'd2;

      // MTLO, then a flushed divide with an ignored MTHI while busy.
      @(negedge clk); lo_we = 1'b1; wdata = 32'h1234;
      @(posedge clk); #1; lo_we = 1'b0;
      chk("mtlo", lo, 32'h1234);
      launch(ALU_DIVU, 32'd100, 32'd7);
      repeat (3) @(posedge clk);
      #1 hi_we = 1'b1; wdata = 32'hDEAD;
      @(posedge clk); #1 hi_we = 1'b0;
      repeat (6) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      chk("flush_busy", 32'(busy), 32'd0);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk("flush_nodone", seen, 0);
      chk("flush_lo", lo, 32'h1234);
      chk("flush_hi", hi, m_hi);

      // MTHI together with start: visible until done overwrites it.
      @(negedge clk);
      start = 1'b1; op = ALU_DIVU; a = 32'd9; b = 32'd2; hi_we = 1'b1; wdata = 32'hABCD;
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0;
      chk("mthi_st_hi", hi, 32'hABCD);
      chk("mthi_st_busy", 32'(busy), 32'd1);
      wait_done(n);
      chk("mthi_st_lat", n, 33);
      chk("mthi_st_hi2", hi, 32'd1);
      chk("mthi_st_lo2", lo, 32'd4);

      // Reset mid-divide.
      launch(ALU_DIV, 32'hFFFFFFF9, 32'd2);
      repeat (14) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_hi", hi, 32'd0);
      chk("mrst_lo", lo, 32'd0);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk("mrst_nodone", seen, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
